// File: rtl/mode_switch_seq.sv
// mode_switch_seq: sequences a safe latch/flip-flop mode change.
// The upstream source is stalled, the downstream clock is gated off, the
// mode select flips, the clock is re-enabled after settling, and ACK pulses.
// Optional build macro MODE_SWITCH_SEQ_STATUS_EN adds the SW_CNT
// completed-switch counter port.
module mode_switch_seq #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic             REQ_MODE,
    output logic             SEL,
    output logic             GATE_EN,
    output logic             HOLD,
    output logic             BUSY,
    output logic             ACK,
    output logic             ERR
`ifdef MODE_SWITCH_SEQ_STATUS_EN
    ,
    output logic [CNT_W-1:0] SW_CNT
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        GATE_OFF,
        SWITCH,
        SETTLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tgt, tgt_nx;
    logic             sel_nx, gate_nx, hold_nx, busy_nx, ack_nx, err_nx;
    logic             phase_end;

    assign phase_end = (cnt == LAST);

    // State, settle counter, latched target mode and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            tgt     <= 1'b1;
            SEL     <= 1'b1;
            GATE_EN <= 1'b1;
            HOLD    <= 1'b0;
            BUSY    <= 1'b0;
            ACK     <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            tgt     <= tgt_nx;
            SEL     <= sel_nx;
            GATE_EN <= gate_nx;
            HOLD    <= hold_nx;
            BUSY    <= busy_nx;
            ACK     <= ack_nx;
            ERR     <= err_nx;
        end
    end

    // Next-state and next-output logic; outputs are computed one edge ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
        tgt_nx   = tgt;
        sel_nx   = SEL;
        gate_nx  = GATE_EN;
        hold_nx  = HOLD;
        busy_nx  = BUSY;
        ack_nx   = 1'b0;
        err_nx   = ERR;

        if (REQ && (state != IDLE)) begin
            err_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (REQ) begin
                    if (REQ_MODE == SEL) begin
                        ack_nx = 1'b1;
                    end else begin
                        state_nx = DRAIN;
                        tgt_nx   = REQ_MODE;
                        hold_nx  = 1'b1;
                        busy_nx  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (phase_end) begin
                    state_nx = GATE_OFF;
                    gate_nx  = 1'b0;
                    cnt_nx   = '0;
                end
            end
            GATE_OFF: begin
                if (phase_end) begin
                    state_nx = SWITCH;
                    cnt_nx   = '0;
                end
            end
            SWITCH: begin
                state_nx = SETTLE;
                sel_nx   = tgt;
                cnt_nx   = '0;
            end
            SETTLE: begin
                if (phase_end) begin
                    state_nx = DONE;
                    gate_nx  = 1'b1;
                    ack_nx   = 1'b1;
                    cnt_nx   = '0;
                end
            end
            DONE: begin
                state_nx = IDLE;
                hold_nx  = 1'b0;
                busy_nx  = 1'b0;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

`ifdef MODE_SWITCH_SEQ_STATUS_EN
    // Completed-switch counter: bumps on each entry into DONE, wraps freely.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SW_CNT <= '0;
        end else if ((state_nx == DONE) && (state != DONE)) begin
            SW_CNT <= SW_CNT + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mode_switch_seq.sv
// tb_mode_switch_seq: directed scenarios plus randomized traffic, checked
// against a timeline model (outputs derived from cycles since acceptance).
module tb_mode_switch_seq;

    localparam int S = 4;
`ifdef MODE_SWITCH_SEQ_STATUS_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic CLK, RST, REQ, REQ_MODE;
    logic SEL, GATE_EN, HOLD, BUSY, ACK, ERR;
`ifdef MODE_SWITCH_SEQ_STATUS_EN
    logic [CW-1:0] SW_CNT;
`endif

    int vectors;
    int miscompares;

    // Reference model state
    bit m_active;
    int m_k;
    bit m_sel, m_tgt, m_err, m_acks;
    int m_swcnt;

    mode_switch_seq #(.SETTLE_CYC(S), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_MODE(REQ_MODE),
        .SEL(SEL), .GATE_EN(GATE_EN), .HOLD(HOLD), .BUSY(BUSY),
        .ACK(ACK), .ERR(ERR)
`ifdef MODE_SWITCH_SEQ_STATUS_EN
        , .SW_CNT(SW_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] obs();
        return {SEL, GATE_EN, HOLD, BUSY, ACK, ERR};
    endfunction

    // Expected {SEL,GATE_EN,HOLD,BUSY,ACK,ERR} from elapsed cycles k.
    function automatic logic [5:0] expv();
        logic s, g;
        if (m_active) begin
            s = (m_k >= 2*S+1) ? m_tgt : m_sel;
            g = !((m_k >= S) && (m_k < 3*S+1));
            return {s, g, 1'b1, 1'b1, (m_k == 3*S+1), m_err};
        end
        return {m_sel, 1'b1, 1'b0, 1'b0, m_acks, m_err};
    endfunction

    // Drive inputs, advance the model by one edge, sample 1 ns after it.
    task automatic step(input bit r, input bit q, input bit m);
        RST = r; REQ = q; REQ_MODE = m;
        if (r) begin
            m_active = 0; m_sel = 1; m_err = 0; m_acks = 0; m_swcnt = 0;
        end else if (m_active) begin
            if (q) m_err = 1;
            m_acks = 0;
            m_k++;
            if (m_k == 3*S+1) m_swcnt = (m_swcnt + 1) % (1 << CW);
            if (m_k == 3*S+2) begin
                m_active = 0;
                m_sel = m_tgt;
            end
        end else begin
            m_acks = 0;
            if (q) begin
                if (m == m_sel) m_acks = 1;
                else begin
                    m_active = 1; m_k = 0; m_tgt = m;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 0, 0);
        vectors++;
        if (obs() !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset got %b want %b", obs(), 6'b110000);
        end
    endtask

    task automatic test_switch();
        step(1, 0, 0);
        for (int k = 0; k <= 3*S+2; k++) begin
            step(0, (k == 0), (k == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL switch k%0d got %b want %b", k, obs(), expv());
            end
            if (k == 0 || k == 3 || k == 4 || k == 8 || k == 9 || k == 13 || k == 14) begin
                logic [5:0] want;
                case (k)
                    0:       want = 6'b111100;
                    3:       want = 6'b111100;
                    4:       want = 6'b101100;
                    8:       want = 6'b101100;
                    9:       want = 6'b001100;
                    13:      want = 6'b011110;
                    default: want = 6'b010000;
                endcase
                vectors++;
                if (obs() !== want) begin
                    miscompares++;
                    $display("FAIL switch_fixed k%0d got %b want %b", k, obs(), want);
                end
            end
        end
    endtask

    task automatic test_same_mode();
        step(1, 0, 0);
        step(0, 1, 1);
        vectors++;
        if (obs() !== 6'b110010) begin
            miscompares++;
            $display("FAIL same_mode_ack got %b want %b", obs(), 6'b110010);
        end
        step(0, 0, 0);
        vectors++;
        if (obs() !== 6'b110000) begin
            miscompares++;
            $display("FAIL same_mode_after got %b want %b", obs(), 6'b110000);
        end
    endtask

    task automatic test_err();
        step(1, 0, 0);
        for (int k = 0; k <= 3*S+3; k++) begin
            step(0, (k == 0) || (k == 6), 1'b0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL err_seq k%0d got %b want %b", k, obs(), expv());
            end
        end
        vectors++;
        if (ERR !== 1'b1 || SEL !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky got ERR=%b SEL=%b want ERR=1 SEL=0", ERR, SEL);
        end
    endtask

    task automatic test_rst_mid();
        step(1, 0, 0);
        step(0, 1, 0);
        for (int k = 1; k <= 9; k++) step(0, 0, 0);
        step(1, 0, 0);
        vectors++;
        if (obs() !== 6'b110000) begin
            miscompares++;
            $display("FAIL rst_mid got %b want %b", obs(), 6'b110000);
        end
        step(0, 0, 0);
        vectors++;
        if (ACK !== 1'b0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_after got ACK=%b BUSY=%b want 0 0", ACK, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0);
        step(0, 1, 0);
        for (int k = 1; k <= 3*S+2; k++) step(0, 0, 0);
        step(0, 1, 1);
        vectors++;
        if (obs() !== 6'b011100 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL back_to_back got %b want %b", obs(), 6'b011100);
        end
    endtask

    task automatic test_random();
        step(1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, q, m;
            r = ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 9) < 2);
            m = 1'($urandom_range(0, 1));
            step(r, q, m);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random cyc%0d got %b want %b", i, obs(), expv());
            end
`ifdef MODE_SWITCH_SEQ_STATUS_EN
            vectors++;
            if (int'(SW_CNT) !== m_swcnt) begin
                miscompares++;
                $display("FAIL random_swcnt cyc%0d got %0d want %0d", i, SW_CNT, m_swcnt);
            end
`endif
        end
    endtask

`ifdef MODE_SWITCH_SEQ_STATUS_EN
    task automatic test_status();
        bit mode;
        step(1, 0, 0);
        mode = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step(0, 1, mode);
            for (int k = 1; k <= 3*S+2; k++) step(0, 0, 0);
            step(0, 1, mode);
            step(0, 0, 0);
            mode = !mode;
        end
        vectors++;
        if (SW_CNT !== 2'd1) begin
            miscompares++;
            $display("FAIL status_cnt got %0d want 1", SW_CNT);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        m_active = 0; m_k = 0; m_sel = 1; m_tgt = 1; m_err = 0; m_acks = 0; m_swcnt = 0;
        RST = 1'b1; REQ = 1'b0; REQ_MODE = 1'b0;
        test_reset();
        test_switch();
        test_same_mode();
        test_err();
        test_rst_mid();
        test_back_to_back();
`ifdef MODE_SWITCH_SEQ_STATUS_EN
        test_status();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
